// File: rtl/uart_param_xcvr.sv
// UART transceiver with configurable data width, parity and stop bits, valid/ready
// byte ports and a first-word fall-through RX FIFO carrying per-byte error flags.
module uart_param_xcvr #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 rx_perr_o,
    output logic                 rx_ferr_o,
    output logic                 rx_ovr_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_BITS + 2;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;

    tx_state_e            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_bit_end;
    logic                 tx_accept;

    // Ready also covers the final cycle of the last stop bit so frames can abut.
    assign tx_bit_end = (tx_cnt_q == BIT_LAST);
    assign tx_ready_o = (tx_state_q == TX_IDLE) ||
                        ((tx_state_q == TX_STOP) && (tx_bit_q == STOP_LAST) && tx_bit_end);
    assign tx_accept  = tx_valid_i && tx_ready_o;
    assign tx_o       = tx_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d = '0;
                        if (PARITY != 0) begin
                            tx_state_d = TX_PAR;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            TX_PAR: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_bit_d   = '0;
                    tx_d       = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                    tx_d = 1'b1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
        if (tx_accept) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_shift_d = tx_data_i;
            tx_par_d   = (PARITY == 1) ? ~^tx_data_i : ^tx_data_i;
            tx_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    rx_state_e            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic                 rx_par_exp;
    logic                 fifo_wr;
    logic [EW-1:0]        fifo_wr_entry;

    // rx_i is asynchronous: only rx_sync_q is used past this point.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_par_exp    = (PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q;
    assign fifo_wr_entry = {rx_perr_q, ~rx_sync_q, rx_shift_q};

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        fifo_wr    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = '0;
                        rx_perr_d  = 1'b0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
            RX_PAR: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_perr_d  = rx_sync_q ^ rx_par_exp;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    fifo_wr    = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [EW-1:0] fifo_head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          ovr_q, ovr_d;
    logic          fifo_empty, fifo_full, fifo_pop, fifo_push;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_pop   = rx_valid_o && rx_ready_i;
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign fifo_push  = fifo_wr && (!fifo_full || fifo_pop);

    always_comb begin
        wr_ptr_d = fifo_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = fifo_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        ovr_d    = ovr_q || (fifo_wr && fifo_full && !fifo_pop);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= fifo_wr_entry;
        end
    end

    assign fifo_head  = fifo_mem[rd_ptr_q[AW-1:0]];
    assign rx_valid_o = !fifo_empty;
    assign rx_data_o  = rx_valid_o ? fifo_head[DATA_BITS-1:0] : '0;
    assign rx_ferr_o  = rx_valid_o && fifo_head[DATA_BITS];
    assign rx_perr_o  = rx_valid_o && fifo_head[DATA_BITS+1];
    assign rx_ovr_o   = ovr_q;

endmodule

// File: tb/tb_uart_param_xcvr.sv
// Self-checking bench for uart_param_xcvr: three instances (8N1, 7E2, 8N2) sharing one clock.
module tb_uart_param_xcvr;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] tx_data0, tx_data2, rx_data0, rx_data2;
    logic [6:0] tx_data1, rx_data1;
    logic tx_valid0, tx_valid1, tx_valid2, tx_ready0, tx_ready1, tx_ready2;
    logic tx0, tx1, tx2, rx_in0, rx_in1;
    logic loop0, loop1, drv0, drv1;
    logic rx_valid0, rx_valid1, rx_valid2, rx_ready0, rx_ready1, rx_ready2;
    logic perr0, perr1, perr2, ferr0, ferr1, ferr2, ovr0, ovr1, ovr2;

    assign rx_in0 = loop0 ? tx0 : drv0;
    assign rx_in1 = loop1 ? tx1 : drv1;

    uart_param_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk_i(clk), .rst_i(rst_n), .tx_data_i(tx_data0), .tx_valid_i(tx_valid0), .tx_ready_o(tx_ready0),
        .tx_o(tx0), .rx_i(rx_in0), .rx_data_o(rx_data0), .rx_valid_o(rx_valid0), .rx_ready_i(rx_ready0),
        .rx_perr_o(perr0), .rx_ferr_o(ferr0), .rx_ovr_o(ovr0));
    uart_param_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk_i(clk), .rst_i(rst_n), .tx_data_i(tx_data1), .tx_valid_i(tx_valid1), .tx_ready_o(tx_ready1),
        .tx_o(tx1), .rx_i(rx_in1), .rx_data_o(rx_data1), .rx_valid_o(rx_valid1), .rx_ready_i(rx_ready1),
        .rx_perr_o(perr1), .rx_ferr_o(ferr1), .rx_ovr_o(ovr1));
    uart_param_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clk_i(clk), .rst_i(rst_n), .tx_data_i(tx_data2), .tx_valid_i(tx_valid2), .tx_ready_o(tx_ready2),
        .tx_o(tx2), .rx_i(tx2), .rx_data_o(rx_data2), .rx_valid_o(rx_valid2), .rx_ready_i(rx_ready2),
        .rx_perr_o(perr2), .rx_ferr_o(ferr2), .rx_ovr_o(ovr2));

    int n_pass, n_total;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] frame;
    } lb_vec_t;
    lb_vec_t lb_tab[4];

    typedef struct packed {
        logic [7:0] d;
        logic       f;
    } rx_ent_t;
    rx_ent_t mq[$];
    logic    exp_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic txl(input int i);
        return (i == 0) ? tx0 : (i == 1) ? tx1 : tx2;
    endfunction

    function automatic logic rdy(input int i);
        return (i == 0) ? tx_ready0 : (i == 1) ? tx_ready1 : tx_ready2;
    endfunction

    function automatic logic rxv(input int i);
        return (i == 0) ? rx_valid0 : rx_valid1;
    endfunction

    // Reference frame: start 0, data LSB first, optional parity, stop ones; bit 0 is first on the wire.
    function automatic logic [15:0] model_frame(input logic [7:0] d, input int nb, input int par, input int nstop);
        logic [15:0] f;
        int ones, pos;
        f = '0;
        ones = 0;
        for (int i = 0; i < nb; i++) begin
            f[1+i] = d[i];
            ones += int'(d[i]);
        end
        pos = 1 + nb;
        if (par != 0) begin
            f[pos] = (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            pos++;
        end
        for (int i = 0; i < nstop; i++) f[pos+i] = 1'b1;
        return f;
    endfunction

    task automatic wait_ready(input int inst);
        int c;
        c = 0;
        while (!rdy(inst) && c < 20 * CPB) begin
            @(negedge clk);
            c++;
        end
        if (!rdy(inst)) check("tx_ready_timeout", 32'(rdy(inst)), 32'd1);
    endtask

    task automatic wait_valid(input int inst, input string name);
        int c;
        c = 0;
        while (!rxv(inst) && c < 12 * CPB) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(rxv(inst)), 32'd1);
    endtask

    task automatic send(input int inst, input logic [7:0] d);
        @(negedge clk);
        case (inst)
            0: begin tx_data0 = d; tx_valid0 = 1'b1; end
            1: begin tx_data1 = d[6:0]; tx_valid1 = 1'b1; end
            default: begin tx_data2 = d; tx_valid2 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        case (inst)
            0: tx_valid0 = 1'b0;
            1: tx_valid1 = 1'b0;
            default: tx_valid2 = 1'b0;
        endcase
    endtask

    task automatic tx_frame(input int inst, input logic [7:0] d, input int nbits, output logic [15:0] bits);
        wait_ready(inst);
        send(inst, d);
        bits = '0;
        repeat (CPB / 2 + 1) @(negedge clk);
        bits[0] = txl(inst);
        for (int b = 1; b < nbits; b++) begin
            repeat (CPB) @(negedge clk);
            bits[b] = txl(inst);
        end
    endtask

    task automatic inject(input int inst, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (inst == 0) drv0 = bits[i];
            else drv1 = bits[i];
            repeat (CPB) @(negedge clk);
        end
        if (inst == 0) drv0 = 1'b1;
        else drv1 = 1'b1;
    endtask

    task automatic pop(input int inst);
        @(negedge clk);
        if (inst == 0) rx_ready0 = 1'b1;
        else rx_ready1 = 1'b1;
        @(posedge clk);
        #1;
        rx_ready0 = 1'b0;
        rx_ready1 = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got;
        int lowc, hi, rdc;
        logic done;

        n_pass = 0; n_total = 0;
        lb_tab[0] = '{8'h41, 16'({1'b1, 8'h41, 1'b0})};
        lb_tab[1] = '{8'h00, 16'({1'b1, 8'h00, 1'b0})};
        lb_tab[2] = '{8'hFF, 16'({1'b1, 8'hFF, 1'b0})};
        lb_tab[3] = '{8'hA5, 16'({1'b1, 8'hA5, 1'b0})};

        rst_n = 1'b1;
        tx_data0 = '0; tx_data1 = '0; tx_data2 = '0;
        tx_valid0 = 1'b0; tx_valid1 = 1'b0; tx_valid2 = 1'b0;
        loop0 = 1'b0; loop1 = 1'b0; drv0 = 1'b1; drv1 = 1'b1;
        rx_ready0 = 1'b0; rx_ready1 = 1'b0; rx_ready2 = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_o", 32'(tx0), 32'd1);
        check("rst_tx_ready", 32'(tx_ready0), 32'd1);
        check("rst_rx_valid", 32'(rx_valid0), 32'd0);
        check("rst_rx_data", 32'(rx_data0), 32'd0);
        check("rst_perr", 32'(perr0), 32'd0);
        check("rst_ferr", 32'(ferr0), 32'd0);
        check("rst_ovr", 32'(ovr0), 32'd0);
        rst_n = 1'b1;
        repeat (4 * CPB) @(negedge clk);

        // 8N1 loopback of 0x41: start bit must last exactly one bit period
        loop0 = 1'b1;
        send(0, 8'h41);
        check("tx_ready_drop", 32'(tx_ready0), 32'd0);
        lowc = 0;
        for (int c = 0; c < 4 * CPB; c++) begin
            @(negedge clk);
            if (tx0) break;
            lowc++;
        end
        check("start_len", 32'(lowc), 32'(CPB));
        wait_valid(0, "lb41_valid");
        check("lb41_data", 32'(rx_data0), 32'h41);
        pop(0);
        check("lb41_empty", 32'(rx_valid0), 32'd0);

        for (int i = 0; i < 4; i++) begin
            tx_frame(0, lb_tab[i].data, 10, got);
            check("lb_frame", 32'(got), 32'(lb_tab[i].frame));
            wait_valid(0, "lb_valid");
            check("lb_data", 32'(rx_data0), 32'(lb_tab[i].data));
            check("lb_perr", 32'(perr0), 32'd0);
            check("lb_ferr", 32'(ferr0), 32'd0);
            pop(0);
        end
        wait_ready(0);
        loop0 = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        // Framing error: stop bit low, data still delivered
        inject(0, 16'({1'b0, 8'hA5, 1'b0}), 10);
        repeat (CPB) @(negedge clk);
        check("ferr_valid", 32'(rx_valid0), 32'd1);
        check("ferr_data", 32'(rx_data0), 32'hA5);
        check("ferr_flag", 32'(ferr0), 32'd1);
        check("ferr_perr", 32'(perr0), 32'd0);
        pop(0);
        check("ferr_empty", 32'(rx_valid0), 32'd0);

        // 3-clock glitch on the idle line must not produce a byte
        @(negedge clk);
        drv0 = 1'b0;
        repeat (3) @(negedge clk);
        drv0 = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_novalid", 32'(rx_valid0), 32'd0);

        // Even parity, 7 data bits
        loop1 = 1'b1;
        tx_frame(1, 8'h55, 11, got);
        check("par_bit", 32'(got[8]), 32'd0);
        check("par_frame", 32'(got), 32'(16'({2'b11, 1'b0, 7'h55, 1'b0})));
        wait_valid(1, "par_lb_valid");
        check("par_lb_data", 32'(rx_data1), 32'h55);
        check("par_lb_perr", 32'(perr1), 32'd0);
        pop(1);
        wait_ready(1);
        loop1 = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        inject(1, 16'({1'b1, 1'b1, 7'h55, 1'b0}), 10);
        repeat (CPB) @(negedge clk);
        check("perr_valid", 32'(rx_valid1), 32'd1);
        check("perr_data", 32'(rx_data1), 32'h55);
        check("perr_flag", 32'(perr1), 32'd1);
        check("perr_ferr", 32'(ferr1), 32'd0);
        pop(1);

        // Overrun: five frames into a four-deep FIFO
        for (int i = 1; i <= 5; i++) inject(0, 16'({1'b1, 8'(i), 1'b0}), 10);
        repeat (CPB) @(negedge clk);
        check("ovr_set", 32'(ovr0), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_pop_valid", 32'(rx_valid0), 32'd1);
            check("ovr_pop_data", 32'(rx_data0), 32'(i));
            pop(0);
        end
        check("ovr_empty", 32'(rx_valid0), 32'd0);
        check("ovr_empty_data", 32'(rx_data0), 32'd0);

        // Reset during TX data bit 3
        loop0 = 1'b1;
        wait_ready(0);
        send(0, 8'h41);
        repeat (4 * CPB + CPB / 2 + 1) @(negedge clk);
        check("midrst_pre_tx", 32'(tx0), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_o", 32'(tx0), 32'd1);
        check("midrst_tx_ready", 32'(tx_ready0), 32'd1);
        check("midrst_rx_valid", 32'(rx_valid0), 32'd0);
        check("midrst_ovr", 32'(ovr0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        tx_frame(0, 8'h41, 10, got);
        check("postrst_frame", 32'(got), 32'(16'({1'b1, 8'h41, 1'b0})));
        wait_valid(0, "postrst_valid");
        check("postrst_data", 32'(rx_data0), 32'h41);
        pop(0);
        wait_ready(0);
        loop0 = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        // Full duplex on u0: random RX frames against a queue model while TX runs random bytes
        exp_ovr = 1'b0;
        fork
            begin : rx_side
                logic [7:0] d;
                logic stopb;
                int npop;
                for (int k = 0; k < 10; k++) begin
                    d = 8'($urandom_range(0, 255));
                    stopb = ($urandom_range(0, 3) != 0);
                    inject(0, 16'({stopb, d, 1'b0}), 10);
                    repeat (CPB) @(negedge clk);
                    if (mq.size() < 4) mq.push_back('{d: d, f: ~stopb});
                    else exp_ovr = 1'b1;
                    npop = $urandom_range(0, 2);
                    for (int p = 0; p < npop; p++) begin
                        if (mq.size() > 0) begin
                            check("rnd_rx_data", 32'(rx_data0), 32'(mq[0].d));
                            check("rnd_rx_ferr", 32'(ferr0), 32'(mq[0].f));
                            pop(0);
                            void'(mq.pop_front());
                        end else begin
                            check("rnd_rx_empty", 32'(rx_valid0), 32'd0);
                        end
                    end
                end
                while (mq.size() > 0) begin
                    check("rnd_drain_data", 32'(rx_data0), 32'(mq[0].d));
                    check("rnd_drain_ferr", 32'(ferr0), 32'(mq[0].f));
                    pop(0);
                    void'(mq.pop_front());
                end
                check("rnd_drain_empty", 32'(rx_valid0), 32'd0);
                check("rnd_ovr", 32'(ovr0), 32'(exp_ovr));
            end
            begin : tx_side
                logic [7:0] d;
                logic [15:0] bits;
                for (int k = 0; k < 6; k++) begin
                    d = 8'($urandom_range(0, 255));
                    tx_frame(0, d, 10, bits);
                    check("rnd_tx0_frame", 32'(bits), 32'(model_frame(d, 8, 0, 1)));
                end
            end
        join

        // Random 7E2 frames on u1
        for (int k = 0; k < 6; k++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 127));
            tx_frame(1, d, 11, got);
            check("rnd_tx1_frame", 32'(got), 32'(model_frame(d, 7, 2, 2)));
        end

        // Back-to-back 8N2: 0x00 then 0xFF with tx_valid held
        wait_ready(2);
        @(negedge clk);
        tx_data2 = 8'h00;
        tx_valid2 = 1'b1;
        @(posedge clk);
        #1;
        tx_data2 = 8'hFF;
        check("b2b_ready_drop", 32'(tx_ready2), 32'd0);
        hi = 0; rdc = 0; done = 1'b0;
        for (int c = 0; c < 14 * CPB && !done; c++) begin
            @(negedge clk);
            if (hi > 0 && !tx2) done = 1'b1;
            else begin
                if (tx2) hi++;
                if (tx_ready2) rdc++;
            end
        end
        tx_valid2 = 1'b0;
        check("b2b_next_start", 32'(done), 32'd1);
        check("b2b_stop_cycles", 32'(hi), 32'(2 * CPB));
        check("b2b_ready_cycles", 32'(rdc), 32'd1);
        wait_ready(2);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
